// File: rtl/maroc_sc_pkg.sv
// Shared MAROC slow-control constants: frame length, field map and receiver FSM states.
// The transmitter imports the same field offsets so both ends agree on the layout.
package maroc_sc_pkg;

  localparam int SC_FRAME_LEN = 829;
  localparam int SC_CNT_W     = 10;

  // Field offset/width map, bit 0 is the first bit on the wire
  localparam int GLOB_LO_OFS  = 0;
  localparam int GLOB_LO_W    = 3;
  localparam int DAC2_OFS     = 3;
  localparam int DAC2_W       = 10;
  localparam int DAC1_OFS     = 13;
  localparam int DAC1_W       = 10;
  localparam int GLOB_MID_OFS = 23;
  localparam int GLOB_MID_W   = 4;
  localparam int MASK_OFS     = 27;
  localparam int MASK_W       = 128;
  localparam int GLOB_HI_OFS  = 155;
  localparam int GLOB_HI_W    = 34;
  localparam int GAIN_OFS     = 189;
  localparam int GAIN_W       = 576;
  localparam int CTEST_OFS    = 765;
  localparam int CTEST_W      = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2
  } sc_state_e;

endpackage

// File: rtl/sc_sync_edge.sv
// N-stage synchroniser for an asynchronous input followed by a rising-edge detector.
// rise_o is a one-cycle pulse, STAGES cycles after the input transition is first sampled.
module sc_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/maroc_sc_receiver.sv
// Receive side of the MAROC slow-control link: deserialises D_SC on CK_SC edges (LSB first)
// and presents the completed frame with decoded DAC and Ctest fields.
module maroc_sc_receiver
  import maroc_sc_pkg::*;
#(
  parameter int FRAME_LEN   = SC_FRAME_LEN,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CK_in,
  input  logic                 rst,
  input  logic                 CK_SC,
  input  logic                 D_SC,
  input  logic                 RSTn_SC,
  output logic [FRAME_LEN-1:0] frame,
  output logic                 frame_done,
  output logic [9:0]           bit_cnt,
  output logic                 overflow,
  output logic [9:0]           dac1,
  output logic [9:0]           dac2,
  output logic [63:0]          ctest_ch
);

  localparam logic [SC_CNT_W-1:0] LAST_IDX = SC_CNT_W'(FRAME_LEN - 1);

  // Assertion is immediate, release is delayed to line up with CK_in
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge CK_in or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_int = rst_sync_q[1];

  logic                   sc_edge;
  logic [SYNC_STAGES-1:0] d_sync_q;
  logic [SYNC_STAGES-1:0] rstn_sync_q;
  logic                   d_s;
  logic                   rstn_s;

  sc_sync_edge #(.STAGES(SYNC_STAGES)) u_ck_sync (
    .clk_i  (CK_in),
    .rst_i  (rst_int),
    .async_i(CK_SC),
    .rise_o (sc_edge)
  );

  // Same depth as the CK_SC chain so the data bit lines up with sc_edge
  always_ff @(posedge CK_in or posedge rst_int) begin
    if (rst_int) begin
      d_sync_q    <= '0;
      rstn_sync_q <= '0;
    end else begin
      d_sync_q    <= {d_sync_q[SYNC_STAGES-2:0], D_SC};
      rstn_sync_q <= {rstn_sync_q[SYNC_STAGES-2:0], RSTn_SC};
    end
  end

  assign d_s    = d_sync_q[SYNC_STAGES-1];
  assign rstn_s = rstn_sync_q[SYNC_STAGES-1];

  sc_state_e               state_q, state_d;
  logic [FRAME_LEN-1:0]    shreg_q, shreg_d;
  logic [FRAME_LEN-1:0]    frame_q, frame_d;
  logic [SC_CNT_W-1:0]     cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    cap_q, cap_d;
  logic                    done_q, done_d;

  always_ff @(posedge CK_in or posedge rst_int) begin
    if (rst_int) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      frame_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      cap_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      cap_q   <= cap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    cap_d   = 1'b0;
    done_d  = 1'b0;

    // A frame that completed last cycle is published even if RSTn_SC drops now
    if (cap_q) begin
      frame_d = shreg_q;
      done_d  = 1'b1;
    end

    if (!rstn_s) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_SHIFT;
        ST_SHIFT: begin
          if (sc_edge) begin
            shreg_d = {d_s, shreg_q[FRAME_LEN-1:1]};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
              state_d = ST_FULL;
              cap_d   = 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (sc_edge) ovf_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign frame      = frame_q;
  assign frame_done = done_q;
  assign bit_cnt    = cnt_q;
  assign overflow   = ovf_q;
  assign dac1       = frame_q[DAC1_OFS +: DAC1_W];
  assign dac2       = frame_q[DAC2_OFS +: DAC2_W];
  assign ctest_ch   = frame_q[CTEST_OFS +: CTEST_W];

endmodule

// File: tb/tb_maroc_sc_receiver.sv
// Bench for maroc_sc_receiver: randomized serial frames, expected frames queued at issue
// and compared by an independent monitor on every frame_done pulse.
module tb_maroc_sc_receiver;

  localparam int N = 829;

  logic          CK_in = 1'b0;
  logic          rst;
  logic          CK_SC;
  logic          D_SC;
  logic          RSTn_SC;
  logic [N-1:0]  frame;
  logic          frame_done;
  logic [9:0]    bit_cnt;
  logic          overflow;
  logic [9:0]    dac1;
  logic [9:0]    dac2;
  logic [63:0]   ctest_ch;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [N-1:0] exp_q[$];

  maroc_sc_receiver dut (
    .CK_in     (CK_in),
    .rst       (rst),
    .CK_SC     (CK_SC),
    .D_SC      (D_SC),
    .RSTn_SC   (RSTn_SC),
    .frame     (frame),
    .frame_done(frame_done),
    .bit_cnt   (bit_cnt),
    .overflow  (overflow),
    .dac1      (dac1),
    .dac2      (dac2),
    .ctest_ch  (ctest_ch)
  );

  always #5 CK_in = ~CK_in;

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every frame_done pops one expected frame; fields are taken from the field map
  always @(negedge CK_in) begin
    logic [N-1:0] e;
    if (frame_done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL frame_done_unexpected: got pulse want none (count %0d)", done_cnt);
      end else begin
        e = exp_q.pop_front();
        chk("frame", frame, e);
        chk("dac1", dac1, e[22:13]);
        chk("dac2", dac2, e[12:3]);
        chk("ctest_ch", ctest_ch, e[828:765]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CK_in);
    #1;
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    D_SC = b;
    cyc(lo);
    CK_SC = 1'b1;
    cyc(hi);
    CK_SC = 1'b0;
  endtask

  task automatic send_frame(input logic [N-1:0] f, input bit min_timing);
    exp_q.push_back(f);
    for (int i = 0; i < N; i++) begin
      if (min_timing) send_bit(f[i], 3, 3);
      else            send_bit(f[i], $urandom_range(3, 5), $urandom_range(3, 5));
    end
    cyc(8);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++)
      send_bit(1'($urandom_range(0, 1)), $urandom_range(3, 5), $urandom_range(3, 5));
    cyc(4);
  endtask

  task automatic pulse_rstn;
    RSTn_SC = 1'b0;
    cyc(4);
    RSTn_SC = 1'b1;
    cyc(6);
  endtask

  function automatic logic [N-1:0] rand_frame();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  initial begin
    logic [N-1:0] f1, f2, f3, f4;

    rst = 1'b1; CK_SC = 1'b0; D_SC = 1'b0; RSTn_SC = 1'b0;
    cyc(5);
    rst = 1'b0;
    cyc(5);
    chk("rst_frame", frame, '0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dac1", dac1, 0);
    chk("rst_ctest", ctest_ch, 0);
    RSTn_SC = 1'b1;
    cyc(6);

    // Full frame with known field values
    f1 = rand_frame();
    f1[22:13]  = 10'h2A5;
    f1[12:3]   = 10'h15A;
    f1[828:765] = 64'hDEADBEEF_01234567;
    send_frame(f1, 1'b0);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_dac1", dac1, 10'h2A5);
    chk("f1_dac2", dac2, 10'h15A);
    chk("f1_ctest", ctest_ch, 64'hDEADBEEF_01234567);
    chk("f1_bit_cnt", bit_cnt, N);
    chk("f1_overflow", overflow, 0);
    pulse_rstn();

    // Abort a partial frame
    send_bits(400);
    chk("abort_cnt_mid", bit_cnt, 400);
    pulse_rstn();
    chk("abort_cnt_cleared", bit_cnt, 0);
    chk("abort_frame_kept", frame, f1);
    chk("abort_done_cnt", done_cnt, 1);

    // Overflow: two extra edges past a full frame
    f2 = rand_frame();
    send_frame(f2, 1'b0);
    chk("ovf_before", overflow, 0);
    send_bits(1);
    chk("ovf_after_830", overflow, 1);
    send_bits(1);
    chk("ovf_bit_cnt", bit_cnt, N);
    chk("ovf_frame", frame, f2);
    chk("ovf_done_cnt", done_cnt, 2);
    pulse_rstn();
    chk("ovf_cleared", overflow, 0);
    chk("ovf_cnt_cleared", bit_cnt, 0);

    // Back-to-back: all ones, then 0x5 pattern at minimum serial clock timing
    f3 = '1;
    send_frame(f3, 1'b0);
    pulse_rstn();
    for (int i = 0; i < N; i++) f4[i] = (i % 2 == 0);
    send_frame(f4, 1'b1);
    chk("b2b_done_cnt", done_cnt, 4);
    chk("b2b_frame", frame, f4);
    pulse_rstn();

    // Reset mid-frame
    send_bits(100);
    rst = 1'b1;
    #2;
    chk("mid_rst_frame", frame, '0);
    chk("mid_rst_bit_cnt", bit_cnt, 0);
    cyc(3);
    rst = 1'b0;
    cyc(4);
    chk("mid_rst_frame_after", frame, '0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_dac2", dac2, 0);
    chk("mid_rst_done_cnt", done_cnt, 4);
    chk("pending_frames", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/maroc_sc_receiver.md
# maroc_sc_receiver

Receive-side model of the MAROC slow-control serial link. The block deserialises the 829-bit configuration frame driven on D_SC/CK_SC/RSTn_SC by the slow-control transmitter, and presents the completed frame plus decoded DAC and Ctest fields. Data arrives LSB first. It is used as a synthesizable loopback/readback checker on the FPGA and as the scoreboard front end in transmitter benches.

## Interface
Parameters:
- FRAME_LEN, 829: number of bits per slow-control frame.
- SYNC_STAGES, 2: synchroniser depth applied to CK_SC, D_SC and RSTn_SC.

Ports:
- CK_in  in  1  system clock. Single clock domain; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- CK_SC  in  1  serial clock from the transmitter, asynchronous to CK_in.
- D_SC  in  1  serial data, valid at the CK_SC rising edge.
- RSTn_SC  in  1  active-low frame reset from the transmitter.
- frame  out  FRAME_LEN  last completed frame; bit 0 is the first bit received.
- frame_done  out  1  one-cycle pulse when a full frame is captured.
- bit_cnt  out  10  number of bits received in the current frame, 0..FRAME_LEN.
- overflow  out  1  sticky flag: more than FRAME_LEN bits arrived since the last RSTn_SC low.
- dac1  out  10  frame[22:13].
- dac2  out  10  frame[12:3].
- ctest_ch  out  64  frame[828:765].

## Operation
- Synchronisation:
  - CK_SC, D_SC and RSTn_SC each pass through SYNC_STAGES flops.
  - A rising-edge detector on the synchronised CK_SC produces `sc_edge`.
  - D_SC is sampled from the same synchroniser stage, so it stays aligned with `sc_edge`.
- FSM states:
  - IDLE: RSTn_SC low, or after reset.
  - SHIFT: receiving bits.
  - FULL: FRAME_LEN bits received.
- Transitions:
  - Synchronised RSTn_SC low, from any state → IDLE. Clears shift register, bit_cnt and overflow. Does not clear `frame`.
  - IDLE → SHIFT when synchronised RSTn_SC is high.
  - SHIFT, on `sc_edge`:
    - shreg ← {D_SC, shreg[FRAME_LEN-1:1]}; bit_cnt increments.
    - When bit_cnt reaches FRAME_LEN → FULL. The next cycle, frame ← shreg and frame_done pulses.
  - FULL, on `sc_edge`: overflow ← 1. shreg, bit_cnt and frame are unchanged.
- RSTn_SC low coinciding with `sc_edge`: the reset wins and the bit is discarded.
- A partial frame aborted by RSTn_SC never updates `frame` and never pulses frame_done.
- Decoded outputs are continuous slices of `frame`; they change only when `frame` updates.
- Reset values: frame 0, frame_done 0, bit_cnt 0, overflow 0, dac1 0, dac2 0, ctest_ch 0. FSM starts in IDLE.

## Timing
- CK_SC high time and low time must each be at least SYNC_STAGES+1 CK_in periods. Faster serial clocks are unsupported; edges may be missed.
- D_SC must be stable from SYNC_STAGES CK_in cycles before the CK_SC rising edge until the same time after it.
- Edge-to-capture latency: a CK_SC rising edge is shifted in SYNC_STAGES+1 CK_in cycles after the pin transition.
- Final-bit-to-frame_done: frame_done is high one cycle after the FRAME_LEN-th shift. `frame` is valid in that same cycle.
- RSTn_SC low takes effect SYNC_STAGES+1 cycles after the pin falls. It must stay low for at least SYNC_STAGES+1 cycles.
- rst asynchronously forces all outputs to their reset values. Deassertion is synchronised internally to CK_in.

## Structure
- Shared package `maroc_sc_pkg`:
  - FRAME_LEN.
  - Field offset/width constants: DAC2 3/10, DAC1 13/10, mask 27/128, GAIN 189/576, Ctest 765/64, plus the remaining global bits.
  - The transmitter imports the same constants.
- Sub-module `sc_sync_edge`: N-stage synchroniser plus rising-edge detector. Instantiated for CK_SC; plain synchronisers are used for D_SC and RSTn_SC.

## Test plan
- Reset: assert rst for 3 cycles mid-frame → all outputs 0, FSM in IDLE, no frame_done.
- Full frame: RSTn_SC high, shift 829 bits with dac1=10'h2A5, dac2=10'h15A, ctest_ch=64'hDEADBEEF_01234567 → one frame_done pulse; fields match; `frame` equals the transmitted vector.
- Abort: 400 bits, then RSTn_SC low for 4 cycles → bit_cnt returns to 0; `frame` keeps the previous value; no frame_done.
- Overflow: 831 CK_SC edges → frame_done once at bit 829; overflow=1 after edge 830; `frame` unchanged. A following RSTn_SC low clears overflow.
- Back-to-back: two frames, all-ones then alternating 0x5 pattern, separated by a 4-cycle RSTn_SC low → two frame_done pulses; second `frame` is the 0x5 pattern.
- Minimum CK_SC: high/low of exactly SYNC_STAGES+1 cycles each → frame captured bit-exact.
